// File: rtl/arm_pkg.sv
// arm_pkg: shared datapath widths and performance-counter select encodings
package arm_pkg;
  localparam int DATA_W = 32;
  localparam int REG_AW = 4;
  localparam int CNT_W  = 32;
  localparam logic [1:0] CNT_RETIRED = 2'd0;
  localparam logic [1:0] CNT_LOAD    = 2'd1;
  localparam logic [1:0] CNT_STORE   = 2'd2;
  localparam logic [1:0] CNT_STALL   = 2'd3;
endpackage

// File: rtl/mem_wb_stage_sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with a clear that beats increment
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o
);
  logic [W-1:0] cnt_q, cnt_d;
  // clear first, then increment unless already saturated
  always_comb cnt_d = clr_i ? '0 : (inc_i && cnt_q != '1) ? cnt_q + W'(1) : cnt_q;
  // count register, async active-low reset
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  assign cnt_o = cnt_q;
endmodule

// File: rtl/mem_wb_stage.sv
// mem_wb_stage: MEM/WB pipeline register, write-back mux and performance counters
module mem_wb_stage import arm_pkg::*; #(
  parameter int DATA_W = arm_pkg::DATA_W,
  parameter int REG_AW = arm_pkg::REG_AW,
  parameter int CNT_W  = arm_pkg::CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              WB_EN,
  input  logic              MEM_R_EN,
  input  logic              MEM_W_EN,
  input  logic [DATA_W-1:0] ALU_Res,
  input  logic [DATA_W-1:0] DataMemory,
  input  logic [REG_AW-1:0] Dest,
  input  logic [DATA_W-1:0] pc,
  input  logic              ready,
  input  logic              flush,
  output logic              WB_WB_EN,
  output logic [REG_AW-1:0] WB_Dest,
  output logic [DATA_W-1:0] WB_Value,
  output logic [DATA_W-1:0] WB_pc,
  output logic              wb_valid,
  input  logic [1:0]        cnt_sel,
  input  logic              cnt_clr,
  output logic [CNT_W-1:0]  cnt_data
);
  logic              accept;
  logic              wb_en_q, valid_q;
  logic [REG_AW-1:0] dest_q;
  logic [DATA_W-1:0] value_q, value_d, pc_q;
  logic [CNT_W-1:0]  cnt_data_q;
  logic [CNT_W-1:0]  cnt [4];
  logic [3:0]        inc;
  // a stalled MEM stage (ready=0) or a flush turns this cycle into a bubble
  assign accept  = ready & ~flush;
  assign value_d = MEM_R_EN ? DataMemory : ALU_Res;
  assign inc[CNT_RETIRED] = accept;
  assign inc[CNT_LOAD]    = accept & MEM_R_EN & WB_EN;
  assign inc[CNT_STORE]   = accept & MEM_W_EN;
  assign inc[CNT_STALL]   = ~ready;
  sat_counter #(.W(CNT_W)) u_retired (.clk, .rst, .inc_i(inc[CNT_RETIRED]), .clr_i(cnt_clr), .cnt_o(cnt[CNT_RETIRED]));
  sat_counter #(.W(CNT_W)) u_load    (.clk, .rst, .inc_i(inc[CNT_LOAD]),    .clr_i(cnt_clr), .cnt_o(cnt[CNT_LOAD]));
  sat_counter #(.W(CNT_W)) u_store   (.clk, .rst, .inc_i(inc[CNT_STORE]),   .clr_i(cnt_clr), .cnt_o(cnt[CNT_STORE]));
  sat_counter #(.W(CNT_W)) u_stall   (.clk, .rst, .inc_i(inc[CNT_STALL]),   .clr_i(cnt_clr), .cnt_o(cnt[CNT_STALL]));
  // capture the MEM result; bubbles clear the strobes but keep the data fields
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      valid_q    <= 1'b0;
      wb_en_q    <= 1'b0;
      dest_q     <= '0;
      value_q    <= '0;
      pc_q       <= '0;
      cnt_data_q <= '0;
    end else begin
      valid_q    <= accept;
      wb_en_q    <= accept & WB_EN;
      cnt_data_q <= cnt[cnt_sel];
      if (accept) begin
        dest_q  <= Dest;
        value_q <= value_d;
        pc_q    <= pc;
      end
    end
  assign WB_WB_EN = wb_en_q;
  assign wb_valid = valid_q;
  assign WB_Dest  = dest_q;
  assign WB_Value = value_q;
  assign WB_pc    = pc_q;
  assign cnt_data = cnt_data_q;
endmodule

// File: tb/tb_mem_wb_stage.sv
// tb_mem_wb_stage: scoreboard bench for the MEM/WB stage and its counters
module tb_mem_wb_stage;
  import arm_pkg::*;
  logic        clk = 1'b0, rst = 1'b0;
  logic        WB_EN, MEM_R_EN, MEM_W_EN, ready, flush, cnt_clr;
  logic [31:0] ALU_Res, DataMemory, pc;
  logic [3:0]  Dest;
  logic        WB_WB_EN, wb_valid;
  logic [3:0]  WB_Dest;
  logic [31:0] WB_Value, WB_pc, cnt_data;
  logic [1:0]  cnt_sel;

  typedef struct { logic wen; logic [3:0] dest; logic [31:0] val; logic [31:0] pc; } exp_t;
  exp_t        q[$];
  logic [31:0] m_cnt [4];
  logic [31:0] m_val;
  int          tests = 0, fails = 0;

  mem_wb_stage dut (
    .clk(clk), .rst(rst), .WB_EN(WB_EN), .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
    .ALU_Res(ALU_Res), .DataMemory(DataMemory), .Dest(Dest), .pc(pc), .ready(ready),
    .flush(flush), .WB_WB_EN(WB_WB_EN), .WB_Dest(WB_Dest), .WB_Value(WB_Value),
    .WB_pc(WB_pc), .wb_valid(wb_valid), .cnt_sel(cnt_sel), .cnt_clr(cnt_clr), .cnt_data(cnt_data)
  );

  always #5 clk = ~clk;

  task automatic idle();
    ready = 1; flush = 1; WB_EN = 0; MEM_R_EN = 0; MEM_W_EN = 0; cnt_clr = 0;
    Dest = 0; ALU_Res = 0; DataMemory = 0; pc = 0;
  endtask

  task automatic clr_model();
    for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    m_val = 0;
    q.delete();
  endtask

  // drive one MEM-stage cycle from a negedge, update the model at the edge, return on the next negedge
  task automatic step(input logic rdy, fl, we, re, se, input logic [3:0] d,
                      input logic [31:0] alu, dm, pcv);
    ready = rdy; flush = fl; WB_EN = we; MEM_R_EN = re; MEM_W_EN = se;
    Dest = d; ALU_Res = alu; DataMemory = dm; pc = pcv;
    @(posedge clk);
    if (rdy && !fl) begin
      m_val = re ? dm : alu;
      q.push_back('{we, d, m_val, pcv});
      if (m_cnt[0] != '1) m_cnt[0]++;
      if (re && we && m_cnt[1] != '1) m_cnt[1]++;
      if (se && m_cnt[2] != '1) m_cnt[2]++;
    end
    if (!rdy && m_cnt[3] != '1) m_cnt[3]++;
    if (cnt_clr) for (int i = 0; i < 4; i++) m_cnt[i] = 0;
    @(negedge clk);
    idle();
  endtask

  task automatic test_reset();
    idle(); clr_model(); rst = 0;
    repeat (2) @(negedge clk);
    tests++;
    if ({WB_WB_EN, wb_valid, WB_Dest, WB_Value, WB_pc, cnt_data} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: wen=%b valid=%b dest=%0d val=%h pc=%h cnt=%h want all 0",
               WB_WB_EN, wb_valid, WB_Dest, WB_Value, WB_pc, cnt_data);
    end
    rst = 1;
  endtask

  task automatic test_counters(input string tag);
    for (int s = 0; s < 4; s++) begin
      cnt_sel = 2'(s);
      @(posedge clk); @(negedge clk);
      tests++;
      if (cnt_data !== m_cnt[s]) begin
        fails++;
        $display("FAIL %s_cnt%0d: got %h want %h", tag, s, cnt_data, m_cnt[s]);
      end
    end
  endtask

  task automatic test_alu();
    exp_t e;
    step(1, 0, 1, 0, 0, 4'd3, 32'hAA55, 32'h0, 32'h100);
    e = q.pop_front();
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Dest, WB_Value, WB_pc} !== {1'b1, e.wen, e.dest, e.val, e.pc}) begin
      fails++;
      $display("FAIL alu_wb: v=%b wen=%b dest=%0d val=%h pc=%h want v=1 wen=%b dest=%0d val=%h pc=%h",
               wb_valid, WB_WB_EN, WB_Dest, WB_Value, WB_pc, e.wen, e.dest, e.val, e.pc);
    end
    test_counters("alu");
  endtask

  task automatic test_load_stall();
    exp_t e;
    int   writes = 0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 0, 1, 0, 4'd7, 32'h40, 32'h0, 32'h104);
      if (WB_WB_EN || wb_valid) writes++;
    end
    step(1, 0, 1, 1, 0, 4'd7, 32'h40, 32'hDEADBEEF, 32'h104);
    if (WB_WB_EN) writes++;
    e = q.pop_front();
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Dest, WB_Value, WB_pc} !== {1'b1, e.wen, e.dest, e.val, e.pc}) begin
      fails++;
      $display("FAIL load_wb: v=%b wen=%b dest=%0d val=%h want v=1 wen=%b dest=%0d val=%h",
               wb_valid, WB_WB_EN, WB_Dest, WB_Value, e.wen, e.dest, e.val);
    end
    @(posedge clk); @(negedge clk);
    if (WB_WB_EN) writes++;
    tests++;
    if (writes != 1) begin
      fails++;
      $display("FAIL load_single_write: got %0d writes want 1", writes);
    end
    test_counters("load");
  endtask

  task automatic test_store();
    exp_t e;
    step(1, 0, 0, 0, 1, 4'd2, 32'h80, 32'h0, 32'h108);
    e = q.pop_front();
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Value} !== {1'b1, e.wen, e.val}) begin
      fails++;
      $display("FAIL store_wb: v=%b wen=%b val=%h want v=1 wen=%b val=%h",
               wb_valid, WB_WB_EN, WB_Value, e.wen, e.val);
    end
    test_counters("store");
  endtask

  task automatic test_flush();
    logic [31:0] held;
    held = m_val;
    step(1, 1, 1, 1, 0, 4'd9, 32'h44, 32'h12345678, 32'h10C);
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Value} !== {2'b00, held} || q.size() != 0) begin
      fails++;
      $display("FAIL flush_drop: v=%b wen=%b val=%h want v=0 wen=0 val=%h",
               wb_valid, WB_WB_EN, WB_Value, held);
    end
    test_counters("flush");
  endtask

  task automatic test_load_nowb();
    exp_t e;
    step(1, 0, 0, 1, 0, 4'd4, 32'h50, 32'h5555, 32'h110);
    e = q.pop_front();
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Value} !== {1'b1, e.wen, e.val}) begin
      fails++;
      $display("FAIL load_nowb: v=%b wen=%b val=%h want v=1 wen=%b val=%h",
               wb_valid, WB_WB_EN, WB_Value, e.wen, e.val);
    end
    test_counters("nowb");
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      step(1, 0, 1'($urandom), 1'($urandom), 1'($urandom), 4'($urandom), $urandom, $urandom, 32'h200 + 32'(4 * i));
      e = q.pop_front();
      tests++;
      if ({wb_valid, WB_WB_EN, WB_Dest, WB_Value, WB_pc} !== {1'b1, e.wen, e.dest, e.val, e.pc}) begin
        fails++;
        $display("FAIL b2b_%0d: wen=%b dest=%0d val=%h pc=%h want wen=%b dest=%0d val=%h pc=%h",
                 i, WB_WB_EN, WB_Dest, WB_Value, WB_pc, e.wen, e.dest, e.val, e.pc);
      end
    end
    test_counters("b2b");
  endtask

  task automatic test_saturation();
    force dut.u_stall.cnt_q = 32'hFFFF_FFFE;
    #1 release dut.u_stall.cnt_q;
    m_cnt[3] = 32'hFFFF_FFFE;
    repeat (3) step(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    test_counters("sat");
    step(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    cnt_sel = CNT_STALL;
    @(posedge clk); @(negedge clk);
    tests++;
    if (cnt_data !== 32'hFFFF_FFFF) begin
      fails++;
      $display("FAIL sat_hold: got %h want ffffffff", cnt_data);
    end
  endtask

  task automatic test_clear();
    cnt_clr = 1;
    step(0, 0, 0, 0, 0, 4'd0, 32'h0, 32'h0, 32'h0);
    test_counters("clr");
  endtask

  task automatic test_reset_midstream();
    step(1, 0, 1, 0, 0, 4'd1, 32'h77, 32'h0, 32'h300);
    void'(q.pop_front());
    ready = 1; flush = 0; WB_EN = 1; MEM_R_EN = 0; Dest = 4'd5; ALU_Res = 32'h12; pc = 32'h304;
    cnt_sel = CNT_RETIRED;
    @(posedge clk);
    #1;
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Dest} !== {2'b11, 4'd5}) begin
      fails++;
      $display("FAIL rstmid_pre: v=%b wen=%b dest=%0d want v=1 wen=1 dest=5", wb_valid, WB_WB_EN, WB_Dest);
    end
    #1 rst = 0;
    #1;
    tests++;
    if ({wb_valid, WB_WB_EN, WB_Dest, WB_Value, cnt_data} !== '0 ||
        {dut.u_retired.cnt_o, dut.u_load.cnt_o, dut.u_store.cnt_o, dut.u_stall.cnt_o} !== '0) begin
      fails++;
      $display("FAIL rstmid_async: v=%b wen=%b dest=%0d val=%h cnt=%h ret=%h want all 0",
               wb_valid, WB_WB_EN, WB_Dest, WB_Value, cnt_data, dut.u_retired.cnt_o);
    end
    @(negedge clk);
    idle(); clr_model();
    rst = 1;
  endtask

  initial begin
    cnt_sel = 0;
    test_reset();
    test_alu();
    test_load_stall();
    test_store();
    test_flush();
    test_load_nowb();
    test_back_to_back();
    test_saturation();
    test_clear();
    test_reset_midstream();
    test_counters("post_rst");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end
endmodule
